// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, immediate formats and the per-opcode control bundle.
package decode_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  typedef struct packed {
    logic     illegal;
    logic     uses_rs1;
    logic     uses_rs2;
    logic     writes_rd;
    logic     alu_src_imm;
    logic     load_en;
    logic     store_en;
    logic     shamt_reg;
    logic     shamt_imm;
    imm_fmt_e imm_fmt;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [6:0] opcode);
    ctrl_t c;
    c         = '0;
    c.imm_fmt = IMM_NONE;
    case (opcode)
      OPC_OP: begin
        c.uses_rs1  = 1'b1;
        c.uses_rs2  = 1'b1;
        c.writes_rd = 1'b1;
        c.shamt_reg = 1'b1;
      end
      OPC_OP_IMM: begin
        c.uses_rs1    = 1'b1;
        c.writes_rd   = 1'b1;
        c.alu_src_imm = 1'b1;
        c.shamt_imm   = 1'b1;
        c.imm_fmt     = IMM_I;
      end
      OPC_LOAD: begin
        c.uses_rs1    = 1'b1;
        c.writes_rd   = 1'b1;
        c.alu_src_imm = 1'b1;
        c.load_en     = 1'b1;
        c.imm_fmt     = IMM_I;
      end
      OPC_STORE: begin
        c.uses_rs1    = 1'b1;
        c.uses_rs2    = 1'b1;
        c.alu_src_imm = 1'b1;
        c.store_en    = 1'b1;
        c.imm_fmt     = IMM_S;
      end
      OPC_BRANCH: begin
        c.uses_rs1 = 1'b1;
        c.uses_rs2 = 1'b1;
        c.imm_fmt  = IMM_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        c.writes_rd   = 1'b1;
        c.alu_src_imm = 1'b1;
        c.imm_fmt     = IMM_U;
      end
      OPC_JAL: begin
        c.writes_rd = 1'b1;
        c.imm_fmt   = IMM_J;
      end
      OPC_JALR: begin
        c.uses_rs1    = 1'b1;
        c.writes_rd   = 1'b1;
        c.alu_src_imm = 1'b1;
        c.imm_fmt     = IMM_I;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// Combinational RV32I/RV64I immediate generator, sign-extended from instr[31] to XLEN.
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  input  imm_fmt_e        fmt_i,
  output logic [XLEN-1:0] imm_o
);

  logic [31:0] w_imm32;

  always_comb begin
    w_imm32 = '0;
    case (fmt_i)
      IMM_I:   w_imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_S:   w_imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_B:   w_imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                          instr_i[11:8], 1'b0};
      IMM_U:   w_imm32 = {instr_i[31:12], 12'b0};
      IMM_J:   w_imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                          instr_i[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end

  // Every format carries its sign in bit 31, so widening to XLEN is a plain signed cast.
  assign imm_o = XLEN'($signed(w_imm32));

endmodule

// File: rtl/decode_stage.sv
// Registered instruction-decode stage between fetch and execute; owns the architectural
// register file, applies the load-use interlock and honours flush and backpressure.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int SHAMT_W  = $clog2(XLEN)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [31:0]        instr_i,
  input  logic [XLEN-1:0]    pc_i,
  input  logic               flush_i,
  input  logic               wb_en_i,
  input  logic [4:0]         wb_rd_i,
  input  logic [XLEN-1:0]    wb_data_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [XLEN-1:0]    pc_o,
  output logic [XLEN-1:0]    rs1_data_o,
  output logic [XLEN-1:0]    rs2_data_o,
  output logic [XLEN-1:0]    imm_o,
  output logic [SHAMT_W-1:0] shamt_o,
  output logic [4:0]         rd_o,
  output logic [2:0]         funct3_o,
  output logic               alt_o,
  output logic               alu_src_imm_o,
  output logic               load_en_o,
  output logic               store_en_o,
  output logic               wb_en_o,
  output logic               illegal_o
);

  localparam int         RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [5:0] NREGS  = 6'(NUM_REGS);

  function automatic logic reg_in_range(input logic [4:0] idx);
    return {1'b0, idx} < NREGS;
  endfunction

  logic [XLEN-1:0]    r_regs [NUM_REGS];
  logic               r_valid;
  logic [XLEN-1:0]    r_pc;
  logic [XLEN-1:0]    r_rs1_data;
  logic [XLEN-1:0]    r_rs2_data;
  logic [XLEN-1:0]    r_imm;
  logic [SHAMT_W-1:0] r_shamt;
  logic [4:0]         r_rd;
  logic [2:0]         r_funct3;
  logic               r_alt;
  logic               r_alu_src_imm;
  logic               r_load_en;
  logic               r_store_en;
  logic               r_wb_en;
  logic               r_illegal;

  logic [6:0]         w_opcode;
  logic [4:0]         w_rs1_idx;
  logic [4:0]         w_rs2_idx;
  logic [4:0]         w_rd_idx;
  ctrl_t              w_ctrl;
  logic               w_bad_reg;
  logic               w_illegal;
  logic [XLEN-1:0]    w_rs1_data;
  logic [XLEN-1:0]    w_rs2_data;
  logic [XLEN-1:0]    w_imm;
  logic [SHAMT_W-1:0] w_shamt;
  logic               w_advance;
  logic               w_hazard;
  logic               w_accept;

  assign w_opcode  = instr_i[6:0];
  assign w_rs1_idx = instr_i[19:15];
  assign w_rs2_idx = instr_i[24:20];
  assign w_rd_idx  = instr_i[11:7];
  assign w_ctrl    = decode_ctrl(w_opcode);

  assign w_bad_reg = (w_ctrl.uses_rs1  && !reg_in_range(w_rs1_idx)) ||
                     (w_ctrl.uses_rs2  && !reg_in_range(w_rs2_idx)) ||
                     (w_ctrl.writes_rd && !reg_in_range(w_rd_idx));
  assign w_illegal = w_ctrl.illegal || w_bad_reg;

  // Write-first read: a writeback landing this cycle is visible to the instruction decoded now.
  always_comb begin
    w_rs1_data = '0;
    if (w_rs1_idx != 5'd0) begin
      if (wb_en_i && (wb_rd_i == w_rs1_idx)) w_rs1_data = wb_data_i;
      else if (reg_in_range(w_rs1_idx))      w_rs1_data = r_regs[w_rs1_idx[RIDX_W-1:0]];
    end
  end

  always_comb begin
    w_rs2_data = '0;
    if (w_rs2_idx != 5'd0) begin
      if (wb_en_i && (wb_rd_i == w_rs2_idx)) w_rs2_data = wb_data_i;
      else if (reg_in_range(w_rs2_idx))      w_rs2_data = r_regs[w_rs2_idx[RIDX_W-1:0]];
    end
  end

  always_comb begin
    w_shamt = '0;
    if (w_ctrl.shamt_reg)      w_shamt = w_rs2_data[SHAMT_W-1:0];
    else if (w_ctrl.shamt_imm) w_shamt = instr_i[20 +: SHAMT_W];
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i (instr_i),
    .fmt_i   (w_ctrl.imm_fmt),
    .imm_o   (w_imm)
  );

  // Handshake: a beat moves on a side only at a rising edge where that side's valid and
  // ready are both high. in_ready_o never depends on in_valid_i; out_valid_o, once high,
  // holds its bundle stable until out_ready_i is seen (or a flush or reset kills it).
  assign w_advance  = !r_valid || out_ready_i;
  assign w_hazard   = r_valid && r_load_en && (r_rd != 5'd0) &&
                      ((w_ctrl.uses_rs1 && (r_rd == w_rs1_idx)) ||
                       (w_ctrl.uses_rs2 && (r_rd == w_rs2_idx)));
  assign in_ready_o = w_advance && !w_hazard && !flush_i;
  assign w_accept   = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (wb_en_i && (wb_rd_i != 5'd0) && reg_in_range(wb_rd_i)) begin
      r_regs[wb_rd_i[RIDX_W-1:0]] <= wb_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid       <= 1'b0;
      r_pc          <= '0;
      r_rs1_data    <= '0;
      r_rs2_data    <= '0;
      r_imm         <= '0;
      r_shamt       <= '0;
      r_rd          <= '0;
      r_funct3      <= '0;
      r_alt         <= 1'b0;
      r_alu_src_imm <= 1'b0;
      r_load_en     <= 1'b0;
      r_store_en    <= 1'b0;
      r_wb_en       <= 1'b0;
      r_illegal     <= 1'b0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (w_advance) begin
      r_valid <= w_accept;
      if (w_accept) begin
        r_pc          <= pc_i;
        r_rs1_data    <= w_rs1_data;
        r_rs2_data    <= w_rs2_data;
        r_imm         <= w_imm;
        r_shamt       <= w_shamt;
        r_rd          <= w_rd_idx;
        r_funct3      <= instr_i[14:12];
        r_alt         <= instr_i[30];
        r_alu_src_imm <= w_ctrl.alu_src_imm;
        r_load_en     <= w_ctrl.load_en && !w_illegal;
        r_store_en    <= w_ctrl.store_en && !w_illegal;
        r_wb_en       <= w_ctrl.writes_rd && (w_rd_idx != 5'd0) && !w_illegal;
        r_illegal     <= w_illegal;
      end
    end
  end

  assign out_valid_o   = r_valid;
  assign pc_o          = r_pc;
  assign rs1_data_o    = r_rs1_data;
  assign rs2_data_o    = r_rs2_data;
  assign imm_o         = r_imm;
  assign shamt_o       = r_shamt;
  assign rd_o          = r_rd;
  assign funct3_o      = r_funct3;
  assign alt_o         = r_alt;
  assign alu_src_imm_o = r_alu_src_imm;
  assign load_en_o     = r_load_en;
  assign store_en_o    = r_store_en;
  assign wb_en_o       = r_wb_en;
  assign illegal_o     = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic against a behavioural model.
module tb_decode_stage;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int SHAMT_W  = 5;

  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_OPIMM  = 7'b0010011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_JALR   = 7'b1100111;

  logic               clk, rst, in_valid, in_ready, flush, wb_en, out_valid, out_ready;
  logic [31:0]        instr;
  logic [XLEN-1:0]    pc, wb_data, pc_out, rs1_data, rs2_data, imm;
  logic [4:0]         wb_rd, rd;
  logic [SHAMT_W-1:0] shamt;
  logic [2:0]         funct3;
  logic               alt, alu_src_imm, load_en, store_en, wb_en_out, illegal;

  int checks;
  int failures;

  typedef struct {
    logic [XLEN-1:0]    pc, rs1, rs2, imm;
    logic [SHAMT_W-1:0] shamt;
    logic [4:0]         rd;
    logic [2:0]         funct3;
    logic               alt, alu_src_imm, load_en, store_en, wb_en, illegal;
  } bundle_t;

  logic [XLEN-1:0] m_regs [NUM_REGS];
  logic            m_valid;
  bundle_t         m_out;
  logic [XLEN-1:0] exp_q[$];

  decode_stage dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .instr_i(instr), .pc_i(pc), .flush_i(flush),
    .wb_en_i(wb_en), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .pc_o(pc_out),
    .rs1_data_o(rs1_data), .rs2_data_o(rs2_data), .imm_o(imm), .shamt_o(shamt),
    .rd_o(rd), .funct3_o(funct3), .alt_o(alt), .alu_src_imm_o(alu_src_imm),
    .load_en_o(load_en), .store_en_o(store_en), .wb_en_o(wb_en_out), .illegal_o(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  function automatic logic [XLEN-1:0] m_read(input logic [4:0] idx);
    if (idx == 5'd0) return '0;
    if (wb_en && wb_rd == idx) return wb_data;
    return m_regs[idx];
  endfunction

  function automatic logic m_uses1(input logic [6:0] op);
    return op == T_OP || op == T_OPIMM || op == T_LOAD || op == T_STORE ||
           op == T_BRANCH || op == T_JALR;
  endfunction

  function automatic logic m_uses2(input logic [6:0] op);
    return op == T_OP || op == T_STORE || op == T_BRANCH;
  endfunction

  function automatic bundle_t m_decode(input logic [31:0] ins, input logic [XLEN-1:0] p);
    bundle_t b;
    int      v;
    int      sgn;
    b        = '{default: '0};
    sgn      = $signed(ins) >>> 31;
    b.pc     = p;
    b.rs1    = m_read(ins[19:15]);
    b.rs2    = m_read(ins[24:20]);
    b.rd     = ins[11:7];
    b.funct3 = ins[14:12];
    b.alt    = ins[30];
    case (ins[6:0])
      T_OP:    begin b.shamt = b.rs2[4:0]; b.wb_en = 1'b1; end
      T_OPIMM: begin v = $signed(ins) >>> 20; b.imm = v; b.shamt = ins[24:20];
                     b.alu_src_imm = 1'b1; b.wb_en = 1'b1; end
      T_LOAD:  begin v = $signed(ins) >>> 20; b.imm = v; b.alu_src_imm = 1'b1;
                     b.load_en = 1'b1; b.wb_en = 1'b1; end
      T_STORE: begin v = ($signed(ins) >>> 25) * 32 + int'(ins[11:7]); b.imm = v;
                     b.alu_src_imm = 1'b1; b.store_en = 1'b1; end
      T_BRANCH: begin v = sgn * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 +
                          int'(ins[11:8]) * 2; b.imm = v; end
      T_LUI, T_AUIPC: begin b.imm = ins & 32'hFFFF_F000; b.alu_src_imm = 1'b1; b.wb_en = 1'b1; end
      T_JAL:   begin v = sgn * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 +
                         int'(ins[30:21]) * 2; b.imm = v; b.wb_en = 1'b1; end
      T_JALR:  begin v = $signed(ins) >>> 20; b.imm = v; b.alu_src_imm = 1'b1; b.wb_en = 1'b1; end
      default: b.illegal = 1'b1;
    endcase
    if (b.rd == 5'd0) b.wb_en = 1'b0;
    return b;
  endfunction

  function automatic logic m_ready();
    logic haz;
    haz = m_valid && m_out.load_en && m_out.rd != 5'd0 &&
          ((m_uses1(instr[6:0]) && m_out.rd == instr[19:15]) ||
           (m_uses2(instr[6:0]) && m_out.rd == instr[24:20]));
    return (!m_valid || out_ready) && !haz && !flush;
  endfunction

  // One clock: the model sees the inputs present before the edge; returns 1 time unit after.
  task automatic tick();
    bundle_t         nb;
    logic            adv, acc, c_rst, c_flush, c_wb;
    logic [4:0]      c_rd;
    logic [XLEN-1:0] c_data;
    adv = !m_valid || out_ready;
    acc = in_valid && m_ready();
    nb  = m_decode(instr, pc);
    c_rst = rst; c_flush = flush; c_wb = wb_en; c_rd = wb_rd; c_data = wb_data;
    @(posedge clk);
    #1;
    if (c_rst) begin
      m_valid = 1'b0;
      m_out   = '{default: '0};
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    end else begin
      if (c_wb && c_rd != 5'd0) m_regs[c_rd] = c_data;
      if (c_flush) m_valid = 1'b0;
      else if (adv) begin
        m_valid = acc;
        if (acc) m_out = nb;
      end
    end
  endtask

  // Order scoreboard: every accepted PC must leave exactly once, in order.
  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL sb_order: unexpected transfer pc=%h", pc_out);
        end else if (pc_out !== exp_q[0]) begin
          failures++; $display("FAIL sb_order: got pc=%h expected %h", pc_out, exp_q[0]);
          void'(exp_q.pop_front());
        end else void'(exp_q.pop_front());
      end else if (out_valid && flush && exp_q.size() != 0) void'(exp_q.pop_front());
      if (in_valid && m_ready()) exp_q.push_back(pc);
    end
  end

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    r[19:15] = 5'($urandom_range(0, 7));
    r[24:20] = 5'($urandom_range(0, 7));
    r[11:7]  = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 11))
      0: r[6:0] = T_OP;       1: r[6:0] = T_OPIMM;  2, 3: r[6:0] = T_LOAD;
      4: r[6:0] = T_STORE;    5: r[6:0] = T_BRANCH; 6: r[6:0] = T_LUI;
      7: r[6:0] = T_AUIPC;    8: r[6:0] = T_JAL;    9: r[6:0] = T_JALR;
      10: r[6:0] = 7'b0001111;
      default: r[6:0] = 7'b1110011;
    endcase
    return r;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    out_ready = 1'b1; instr = '0; pc = '0;
    tick(); tick();
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++;
    if ({pc_out, rs1_data, rs2_data, imm, shamt, rd, funct3, alt, alu_src_imm, load_en, store_en,
         wb_en_out, illegal} !== '0) begin
      failures++; $display("FAIL reset_outputs: got pc=%h imm=%h rd=%0d expected all zero", pc_out, imm, rd);
    end
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_addi();
    in_valid = 1'b1; instr = 32'h0050_0093; pc = 32'h100;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL addi_ready: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid: got %b expected 1", out_valid); end
    checks++; if (imm !== 32'd5) begin failures++; $display("FAIL addi_imm: got %h expected 5", imm); end
    checks++; if (rd !== 5'd1) begin failures++; $display("FAIL addi_rd: got %0d expected 1", rd); end
    checks++; if (alu_src_imm !== 1'b1) begin failures++; $display("FAIL addi_src: got %b expected 1", alu_src_imm); end
    checks++; if (wb_en_out !== 1'b1) begin failures++; $display("FAIL addi_wb: got %b expected 1", wb_en_out); end
    checks++; if (rs1_data !== '0) begin failures++; $display("FAIL addi_rs1: got %h expected 0", rs1_data); end
    checks++; if (pc_out !== 32'h100) begin failures++; $display("FAIL addi_pc: got %h expected 100", pc_out); end
  endtask

  task automatic test_branch_imm();
    in_valid = 1'b1; instr = 32'hFE20_8CE3; pc = 32'h104;
    tick();
    in_valid = 1'b0;
    checks++; if (imm !== 32'hFFFF_FFF8) begin failures++; $display("FAIL beq_imm: got %h expected fffffff8", imm); end
    checks++; if (wb_en_out !== 1'b0) begin failures++; $display("FAIL beq_wb: got %b expected 0", wb_en_out); end
    checks++; if (alu_src_imm !== 1'b0) begin failures++; $display("FAIL beq_src: got %b expected 0", alu_src_imm); end
  endtask

  task automatic test_load_use();
    int low;
    in_valid = 1'b1; instr = 32'h0000_A103; pc = 32'h200;
    tick();
    instr = 32'h0011_01B3; pc = 32'h204;
    #1;
    low = 0;
    while (!in_ready && low < 8) begin
      low++;
      tick();
      #1;
    end
    checks++; if (low != 1) begin failures++; $display("FAIL loaduse_stall: got %0d stall cycles expected 1", low); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL loaduse_bubble: got valid %b expected 0", out_valid); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || rd !== 5'd3 || pc_out !== 32'h204) begin
      failures++; $display("FAIL loaduse_issue: got valid=%b rd=%0d pc=%h expected 1/3/204", out_valid, rd, pc_out);
    end
  endtask

  task automatic test_bypass();
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'hDEAD_BEEF;
    in_valid = 1'b1; instr = 32'h0000_81B3; pc = 32'h300;
    tick();
    checks++; if (rs1_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL bypass_rs1: got %h expected deadbeef", rs1_data); end
    checks++; if (rs2_data !== '0) begin failures++; $display("FAIL bypass_rs2_x0: got %h expected 0", rs2_data); end
    wb_rd = 5'd0; wb_data = 32'h1234; instr = 32'h0000_01B3; pc = 32'h304;
    tick();
    checks++; if (rs1_data !== '0 || rs2_data !== '0) begin
      failures++; $display("FAIL x0_same_cycle: got rs1=%h rs2=%h expected 0", rs1_data, rs2_data);
    end
    wb_en = 1'b0; pc = 32'h308;
    tick();
    checks++; if (rs1_data !== '0 || rs2_data !== '0) begin
      failures++; $display("FAIL x0_later: got rs1=%h rs2=%h expected 0", rs1_data, rs2_data);
    end
    instr = 32'h0000_81B3; pc = 32'h30C;
    tick();
    in_valid = 1'b0;
    checks++; if (rs1_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL regfile_x1: got %h expected deadbeef", rs1_data); end
  endtask

  task automatic test_backpressure();
    logic [XLEN-1:0] s_pc, s_imm;
    logic [4:0]      s_rd;
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h0070_0293; pc = 32'h400;
    tick();
    s_pc = pc_out; s_imm = imm; s_rd = rd;
    out_ready = 1'b0; instr = 32'h0090_0313; pc = 32'h404;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready: cycle %0d got %b expected 0", k, in_ready); end
      tick();
      checks++; if (out_valid !== 1'b1 || pc_out !== 32'h400 || imm !== 32'd7 || rd !== 5'd5 ||
                    pc_out !== s_pc || imm !== s_imm || rd !== s_rd) begin
        failures++; $display("FAIL bp_hold: got valid=%b pc=%h imm=%h rd=%0d expected 1/400/7/5", out_valid, pc_out, imm, rd);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_release: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || pc_out !== 32'h404 || imm !== 32'd9 || rd !== 5'd6) begin
      failures++; $display("FAIL bp_next: got valid=%b pc=%h imm=%h rd=%0d expected 1/404/9/6", out_valid, pc_out, imm, rd);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_dup: got valid %b expected 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1; in_valid = 1'b1; instr = 32'h0010_0393; pc = 32'h500; flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL flush_ready: got %b expected 0", in_ready); end
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_incoming: got valid %b expected 0", out_valid); end
    pc = 32'h504;
    tick();
    out_ready = 1'b0; in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_held: got valid %b expected 0", out_valid); end
  endtask

  task automatic test_random();
    logic hold;
    hold = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        instr    = rand_instr();
        pc       = $urandom;
      end
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      wb_en     = 1'($urandom_range(0, 1));
      wb_rd     = 5'($urandom_range(0, 7));
      wb_data   = $urandom;
      #1;
      checks++; if (in_ready !== m_ready()) begin
        failures++; $display("FAIL rand_ready: cycle %0d got %b expected %b", n, in_ready, m_ready());
      end
      hold = in_valid && !m_ready() && !flush;
      tick();
      checks++; if (out_valid !== m_valid) begin
        failures++; $display("FAIL rand_valid: cycle %0d got %b expected %b", n, out_valid, m_valid);
      end
      if (m_valid) begin
        checks++;
        if (pc_out !== m_out.pc || rs1_data !== m_out.rs1 || rs2_data !== m_out.rs2 || imm !== m_out.imm ||
            shamt !== m_out.shamt || rd !== m_out.rd || funct3 !== m_out.funct3 || alt !== m_out.alt ||
            alu_src_imm !== m_out.alu_src_imm || load_en !== m_out.load_en || store_en !== m_out.store_en ||
            wb_en_out !== m_out.wb_en || illegal !== m_out.illegal) begin
          failures++;
          $display("FAIL rand_bundle: cycle %0d got pc=%h rs1=%h rs2=%h imm=%h sh=%0d rd=%0d f3=%0d alt=%b src=%b ld=%b st=%b wb=%b ill=%b required pc=%h rs1=%h rs2=%h imm=%h sh=%0d rd=%0d f3=%0d alt=%b src=%b ld=%b st=%b wb=%b ill=%b",
                   n, pc_out, rs1_data, rs2_data, imm, shamt, rd, funct3, alt, alu_src_imm, load_en, store_en, wb_en_out, illegal,
                   m_out.pc, m_out.rs1, m_out.rs2, m_out.imm, m_out.shamt, m_out.rd, m_out.funct3, m_out.alt,
                   m_out.alu_src_imm, m_out.load_en, m_out.store_en, m_out.wb_en, m_out.illegal);
        end
      end
    end
    in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    logic [4:0] idx;
    out_ready = 1'b1; flush = 1'b0;
    for (int i = 1; i < 8; i++) begin
      wb_en = 1'b1; wb_rd = 5'(i); wb_data = $urandom | 32'h1;
      in_valid = 1'b1; instr = 32'h0000_A103; pc = 32'h600 + 32'(i * 4);
      tick();
    end
    rst = 1'b1; wb_rd = 5'd9; wb_data = 32'hFFFF_FFFF;
    tick();
    rst = 1'b0; wb_en = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_valid: got %b expected 0", out_valid); end
    checks++; if ({pc_out, rs1_data, imm, rd, load_en, wb_en_out} !== '0) begin
      failures++; $display("FAIL midreset_outputs: got pc=%h imm=%h rd=%0d expected zero", pc_out, imm, rd);
    end
    for (int i = 1; i < NUM_REGS; i++) begin
      idx = 5'(i);
      instr = {7'b0, idx, idx, 3'b000, 5'd3, T_OP}; pc = 32'h700 + 32'(i * 4);
      tick();
      checks++; if (out_valid !== 1'b1 || rs1_data !== '0 || rs2_data !== '0) begin
        failures++; $display("FAIL midreset_reg: x%0d got valid=%b rs1=%h rs2=%h expected 1/0/0", i, out_valid, rs1_data, rs2_data);
      end
    end
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL sb_drain: got %0d pending expected 0", exp_q.size()); end
  endtask

  initial begin
    checks = 0; failures = 0;
    m_valid = 1'b0; m_out = '{default: '0};
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    test_reset();
    test_addi();
    test_branch_imm();
    test_load_use();
    test_bypass();
    test_backpressure();
    test_flush();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
